// File: rtl/conv_pe_sequencer.sv
// Sequences channel-group beats of 3x3x8 windows into a convolution PE and
// tracks completed pixels until the layer drains; rejects zero-sized layers.
module conv_pe_sequencer #(
    parameter int CG_W  = 8,
    parameter int PIX_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cfg_start,
    input  logic [CG_W-1:0]  cfg_cin_groups,
    input  logic [PIX_W-1:0] cfg_num_pixels,
    input  logic             win_valid,
    output logic             win_ready,
    output logic             pe_valid,
    output logic             pe_last,
    output logic [CG_W-1:0]  wgt_addr,
    input  logic             pe_result_valid,
    output logic             busy,
    output logic             done,
    output logic             err_cfg,
    output logic [1:0]       dbg_state
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t           state;
    logic [CG_W-1:0]  cin_groups;
    logic [PIX_W-1:0] num_pixels;
    logic [CG_W-1:0]  grp_cnt;
    logic [PIX_W-1:0] pix_cnt;
    logic [PIX_W-1:0] res_cnt;
    logic             err_q;

    logic grp_last;
    logic pix_last;
    logic res_full;
    logic beat;
    logic in_flight;

    // Handshake: a window transfers on any cycle where win_valid and
    // win_ready are both high; win_ready depends only on state, never on
    // win_valid, and a window held valid without ready simply waits.
    assign grp_last  = (grp_cnt == cin_groups - CG_W'(1));
    assign pix_last  = (pix_cnt == num_pixels - PIX_W'(1));
    assign res_full  = (res_cnt == num_pixels);
    assign in_flight = (state == S_RUN) || (state == S_DRAIN);
    assign beat      = win_valid && (state == S_RUN) && !rst;

    assign win_ready = (state == S_RUN) && !rst;
    assign pe_valid  = beat;
    assign pe_last   = beat && grp_last;
    assign wgt_addr  = rst ? '0 : grp_cnt;
    assign busy      = in_flight && !rst;
    assign done      = (state == S_DONE) && !rst;
    assign err_cfg   = err_q && !rst;
    assign dbg_state = state;

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= S_IDLE;
            cin_groups <= '0;
            num_pixels <= '0;
            grp_cnt    <= '0;
            pix_cnt    <= '0;
            res_cnt    <= '0;
            err_q      <= 1'b0;
        end else begin
            err_q <= 1'b0;
            // Results are counted in RUN as well, so one landing with the
            // final beat is not lost.
            if (pe_result_valid && in_flight && !res_full)
                res_cnt <= res_cnt + PIX_W'(1);
            case (state)
                S_IDLE: begin
                    if (cfg_start) begin
                        if (cfg_cin_groups != '0 && cfg_num_pixels != '0) begin
                            cin_groups <= cfg_cin_groups;
                            num_pixels <= cfg_num_pixels;
                            grp_cnt    <= '0;
                            pix_cnt    <= '0;
                            res_cnt    <= '0;
                            state      <= S_RUN;
                        end else begin
                            err_q <= 1'b1;
                        end
                    end
                end
                S_RUN: begin
                    if (beat) begin
                        if (grp_last) begin
                            grp_cnt <= '0;
                            pix_cnt <= pix_cnt + PIX_W'(1);
                            if (pix_last)
                                state <= S_DRAIN;
                        end else begin
                            grp_cnt <= grp_cnt + CG_W'(1);
                        end
                    end
                end
                S_DRAIN: begin
                    if (res_full)
                        state <= S_DONE;
                end
                S_DONE: begin
                    state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_conv_pe_sequencer.sv
// Directed bench for conv_pe_sequencer with a 5-cycle PE result model that
// can be overridden to place results on chosen cycles.
module tb_conv_pe_sequencer;

    logic        clk = 1'b0;
    logic        rst;
    logic        cfg_start;
    logic [7:0]  cfg_cin_groups;
    logic [15:0] cfg_num_pixels;
    logic        win_valid;
    logic        win_ready;
    logic        pe_valid;
    logic        pe_last;
    logic [7:0]  wgt_addr;
    logic        pe_result_valid;
    logic        busy;
    logic        done;
    logic        err_cfg;
    logic [1:0]  dbg_state;

    int checks = 0;
    int errors = 0;
    int res_seen = 0;
    int res_base;

    logic [4:0] pe_pipe = '0;
    logic       manual_mode = 1'b0;
    logic       manual_res  = 1'b0;

    always #5 clk = ~clk;

    conv_pe_sequencer dut (
        .clk(clk), .rst(rst), .cfg_start(cfg_start),
        .cfg_cin_groups(cfg_cin_groups), .cfg_num_pixels(cfg_num_pixels),
        .win_valid(win_valid), .win_ready(win_ready), .pe_valid(pe_valid),
        .pe_last(pe_last), .wgt_addr(wgt_addr), .pe_result_valid(pe_result_valid),
        .busy(busy), .done(done), .err_cfg(err_cfg), .dbg_state(dbg_state)
    );

    // PE pipeline: one result five cycles after each last-channel beat.
    always @(posedge clk) begin
        pe_pipe <= {pe_pipe[3:0], pe_valid & pe_last};
        if (pe_result_valid === 1'b1)
            res_seen <= res_seen + 1;
    end
    assign pe_result_valid = manual_mode ? manual_res : pe_pipe[4];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_win_ready"}, 32'(win_ready), 0);
        chk({tag, "_pe_valid"},  32'(pe_valid), 0);
        chk({tag, "_pe_last"},   32'(pe_last), 0);
        chk({tag, "_wgt_addr"},  32'(wgt_addr), 0);
        chk({tag, "_busy"},      32'(busy), 0);
        chk({tag, "_done"},      32'(done), 0);
        chk({tag, "_err_cfg"},   32'(err_cfg), 0);
    endtask

    // Start request in IDLE, then one stall cycle in RUN with win_valid low.
    task automatic start_cfg(input logic [7:0] cin, input logic [15:0] num);
        @(negedge clk);
        cfg_start = 1'b1; cfg_cin_groups = cin; cfg_num_pixels = num; win_valid = 1'b0;
        #1 chk("start_idle_busy", 32'(busy), 0);
        @(negedge clk);
        cfg_start = 1'b0;
        #1;
        chk("start_run_busy", 32'(busy), 1);
        chk("start_run_ready", 32'(win_ready), 1);
        chk("start_stall_pe_valid", 32'(pe_valid), 0);
        chk("start_wgt_addr", 32'(wgt_addr), 0);
        res_base = res_seen;
    endtask

    task automatic beat(input int exp_addr, input logic exp_last);
        @(negedge clk);
        win_valid = 1'b1;
        #1;
        chk("beat_pe_valid", 32'(pe_valid), 1);
        chk("beat_wgt_addr", 32'(wgt_addr), 32'(exp_addr));
        chk("beat_pe_last", 32'(pe_last), 32'(exp_last));
    endtask

    // Waits a bounded number of cycles after the last beat and checks when
    // done pulses, that it pulses once, and that busy has fallen.
    task automatic wait_done(input int exp_k, input int exp_res);
        int first_k;
        int n_done;
        first_k = -1;
        n_done = 0;
        for (int k = 1; k <= 30; k++) begin
            @(negedge clk);
            win_valid = 1'b0;
            manual_res = 1'b0;
            #1;
            if (k == 1) begin
                chk("drain_ready", 32'(win_ready), 0);
                chk("drain_busy", 32'(busy), 1);
            end
            if (done === 1'b1) begin
                n_done++;
                if (first_k < 0) first_k = k;
            end
        end
        chk("done_cycle", 32'(first_k), 32'(exp_k));
        chk("done_count", 32'(n_done), 1);
        chk("end_busy", 32'(busy), 0);
        chk("end_ready", 32'(win_ready), 0);
        chk("result_count", 32'(res_seen - res_base), 32'(exp_res));
    endtask

    initial begin
        rst = 1'b1; cfg_start = 1'b0; cfg_cin_groups = '0; cfg_num_pixels = '0;
        win_valid = 1'b0;
        @(negedge clk);
        #1 check_all_zero("reset");
        @(negedge clk);
        rst = 1'b0;
        #1 check_all_zero("idle");
        chk("idle_state", 32'(dbg_state), 0);

        // cin=3, pix=2, win_valid held high
        start_cfg(8'd3, 16'd2);
        for (int b = 0; b < 6; b++) beat(b % 3, (b % 3) == 2);
        wait_done(7, 2);

        // cin=1, pix=4, win_valid toggling
        start_cfg(8'd1, 16'd4);
        for (int i = 0; i < 7; i++) begin
            @(negedge clk);
            win_valid = (i % 2 == 0);
            #1;
            chk("tog_pe_valid", 32'(pe_valid), 32'(i % 2 == 0));
            chk("tog_pe_last", 32'(pe_last), 32'(i % 2 == 0));
            chk("tog_wgt_addr", 32'(wgt_addr), 0);
            chk("tog_ready", 32'(win_ready), 1);
        end
        wait_done(7, 4);

        // zero cin_groups, then zero num_pixels
        for (int t = 0; t < 2; t++) begin
            @(negedge clk);
            cfg_start = 1'b1;
            cfg_cin_groups = (t == 0) ? 8'd0 : 8'd2;
            cfg_num_pixels = (t == 0) ? 16'd5 : 16'd0;
            #1 chk("err_before", 32'(err_cfg), 0);
            @(negedge clk);
            cfg_start = 1'b0; win_valid = 1'b1;
            #1;
            chk("err_pulse", 32'(err_cfg), 1);
            chk("err_busy", 32'(busy), 0);
            chk("err_pe_valid", 32'(pe_valid), 0);
            @(negedge clk);
            #1;
            chk("err_clear", 32'(err_cfg), 0);
            chk("err_pe_valid2", 32'(pe_valid), 0);
            chk("err_state", 32'(dbg_state), 0);
            win_valid = 1'b0;
        end

        // restart mid-RUN ignored
        start_cfg(8'd2, 16'd2);
        for (int b = 0; b < 4; b++) begin
            @(negedge clk);
            win_valid = 1'b1;
            cfg_start = (b == 1);
            cfg_cin_groups = 8'd5; cfg_num_pixels = 16'd7;
            #1;
            chk("ign_wgt_addr", 32'(wgt_addr), 32'(b % 2));
            chk("ign_pe_last", 32'(pe_last), 32'(b % 2 == 1));
            if (b == 2) chk("ign_err", 32'(err_cfg), 0);
        end
        cfg_start = 1'b0;
        wait_done(7, 2);

        // reset after 3 of 6 beats
        start_cfg(8'd3, 16'd2);
        for (int b = 0; b < 3; b++) beat(b, b == 2);
        @(negedge clk);
        rst = 1'b1; win_valid = 1'b1;
        #1 check_all_zero("in_reset");
        @(negedge clk);
        rst = 1'b0; win_valid = 1'b0;
        #1 check_all_zero("after_reset");
        begin
            int seen_done;
            seen_done = 0;
            for (int k = 0; k < 10; k++) begin
                @(negedge clk);
                #1 if (done === 1'b1 || busy === 1'b1) seen_done++;
            end
            chk("abandon_no_done", 32'(seen_done), 0);
        end
        start_cfg(8'd2, 16'd1);
        beat(0, 1'b0);
        beat(1, 1'b1);
        wait_done(7, 1);

        // maximum channel groups
        start_cfg(8'd255, 16'd1);
        for (int b = 0; b < 255; b++) beat(b, b == 254);
        wait_done(7, 1);

        // final result forced onto the last RUN beat
        manual_mode = 1'b1;
        start_cfg(8'd1, 16'd2);
        @(negedge clk);
        win_valid = 1'b1; manual_res = 1'b1;
        #1 chk("force_b0_last", 32'(pe_last), 1);
        @(negedge clk);
        win_valid = 1'b1; manual_res = 1'b1;
        #1 chk("force_b1_last", 32'(pe_last), 1);
        wait_done(2, 2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/conv_pe_sequencer.md
CONV_PE_SEQUENCER -- requirements
Module: conv_pe_sequencer

Interface
- REQ-001: Parameters: CG_W, default 8, width of the channel-group count (one group = 8 input channels); PIX_W, default 16, width of the output-pixel count.
- REQ-002: clk  input  1  clock; all logic rising-edge.
- REQ-003: rst  input  1  reset, synchronous, active-high.
- REQ-004: cfg_start  input  1  one-cycle layer start request.
- REQ-005: cfg_cin_groups  input  CG_W  channel groups per output pixel (Cin/8); sampled on an accepted cfg_start.
- REQ-006: cfg_num_pixels  input  PIX_W  output pixels in the layer; sampled on an accepted cfg_start.
- REQ-007: win_valid  input  1  upstream 3x3x8 window available.
- REQ-008: win_ready  output  1  sequencer accepts the window this cycle.
- REQ-009: pe_valid  output  1  drives PE valid_in.
- REQ-010: pe_last  output  1  drives PE last_channel.
- REQ-011: wgt_addr  output  CG_W  weight/bias buffer group index for the current beat.
- REQ-012: pe_result_valid  input  1  PE data_valid (one per completed pixel).
- REQ-013: busy  output  1  high in RUN and DRAIN.
- REQ-014: done  output  1  one-cycle pulse at layer completion.
- REQ-015: err_cfg  output  1  one-cycle pulse on a rejected configuration.

Function
- REQ-016: FSM states are IDLE, RUN, DRAIN and DONE.
- REQ-017: IDLE -> RUN on cfg_start when both cfg_cin_groups != 0 and cfg_num_pixels != 0; the block latches both values and clears grp_cnt, pix_cnt and res_cnt.
- REQ-018: In IDLE, cfg_start with either value zero pulses err_cfg for one cycle the next cycle and stays in IDLE.
- REQ-019: cfg_start outside IDLE is ignored (no latch, no err_cfg).
- REQ-020: win_ready = 1 only in RUN; it is 0 in IDLE, DRAIN and DONE.
- REQ-021: Beat = cycle with win_valid & win_ready; pe_valid = beat (combinational, zero latency) and is 0 otherwise.
- REQ-022: wgt_addr = grp_cnt at all times; pe_last = beat & (grp_cnt == cin_groups-1).
- REQ-023: Per beat, grp_cnt increments; it wraps to 0 after cin_groups-1, and pix_cnt increments on that wrap.
- REQ-024: A beat with pe_last and pix_cnt == num_pixels-1 moves RUN -> DRAIN; no further beats are issued.
- REQ-025: win_valid low in RUN stalls with all counters held; there is no timeout.
- REQ-026: res_cnt increments on each pe_result_valid in RUN or DRAIN and saturates at num_pixels; pe_result_valid is ignored in IDLE and DONE.
- REQ-027: DRAIN -> DONE in the cycle after res_cnt reaches num_pixels, including when the final pe_result_valid coincides with the final RUN beat.
- REQ-028: done = 1 exactly in DONE, for one cycle; DONE -> IDLE unconditionally.
- REQ-029: busy = (state == RUN) | (state == DRAIN).
- REQ-030: With cin_groups = 1, every beat asserts pe_last and wgt_addr stays 0.
- REQ-031: Counters use full-width compares; cin_groups = 2^CG_W-1 and num_pixels = 2^PIX_W-1 operate without overflow.
- REQ-032: Expected latency: last beat -> final pe_result_valid is 5 cycles (PE pipeline); done follows 2 cycles later (DRAIN, then DONE).

Reset
- REQ-033: rst in any state forces IDLE and clears grp_cnt, pix_cnt, res_cnt and the latched config the next cycle.
- REQ-034: Under reset, win_ready, pe_valid, pe_last, busy, done and err_cfg are 0, and wgt_addr is 0.
- REQ-035: rst mid-RUN or mid-DRAIN abandons the layer with no done pulse; results after reset are ignored until the next start.

Verification
- REQ-036: cin_groups=3, num_pixels=2, win_valid held 1 -> pe_valid for 6 cycles, wgt_addr 0,1,2,0,1,2, pe_last on beats 3 and 6; PE model returns 2 results; done pulses once, and busy then falls.
- REQ-037: cin_groups=1, num_pixels=4, win_valid toggling 1/0 -> 4 beats spaced 2 cycles apart, each with pe_last=1 and wgt_addr=0, then done.
- REQ-038: cfg_start with cin_groups=0 (and separately num_pixels=0) -> err_cfg pulse 1 cycle, busy stays 0, and pe_valid is never asserted.
- REQ-039: cfg_start pulsed again mid-RUN with different values -> ignored; the original counts complete and done pulses once.
- REQ-040: rst after 3 of 6 beats -> all outputs 0 next cycle and no done; a fresh start with cin_groups=2, num_pixels=1 completes normally.
- REQ-041: Final pe_result_valid coincident with the last RUN beat (forced by the model) -> DONE entered correctly, one done pulse.
